// File: rtl/tl_phase_fsm_pkg.sv
// Shared types for the traffic-light phase controller: phase/sub-state enums,
// lamp encodings, default durations and the normal phase successor.
package tl_pkg;

    typedef enum logic [2:0] {
        MAIN_G    = 3'd0,
        MAIN_Y    = 3'd1,
        ALL_RED_A = 3'd2,
        SIDE_G    = 3'd3,
        SIDE_Y    = 3'd4,
        ALL_RED_B = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } sub_e;

    // Lamp encodings are {R,Y,G}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam int DEF_T_MAIN_G = 30;
    localparam int DEF_T_SIDE_G = 20;
    localparam int DEF_T_YELLOW = 4;
    localparam int DEF_T_ALLRED = 2;
    localparam int DEF_T_PED    = 10;

    function automatic phase_e next_phase(input phase_e p, input logic ped);
        case (p)
            MAIN_G:    return MAIN_Y;
            MAIN_Y:    return ALL_RED_A;
            ALL_RED_A: return SIDE_G;
            SIDE_G:    return SIDE_Y;
            SIDE_Y:    return ALL_RED_B;
            ALL_RED_B: return ped ? PED_WALK : MAIN_G;
            PED_WALK:  return MAIN_G;
            FLASH:     return ALL_RED_B;
            default:   return ALL_RED_B;
        endcase
    endfunction

endpackage

// File: rtl/tl_phase_fsm_if.sv
// Handshake between the phase controller and the downstream seconds timer.
interface tl_phase_fsm_if;
    logic        timer_enable;
    logic        timer_reset;
    logic [15:0] timer_seconds;
    logic        timer_finished;

    modport master (output timer_enable, output timer_reset, output timer_seconds,
                    input timer_finished);
    modport slave  (input timer_enable, input timer_reset, input timer_seconds,
                    output timer_finished);
endinterface

// File: rtl/tl_phase_fsm_light_decode.sv
// Phase (+ night blink bit) to lamp pattern; purely combinational.
// Flashing lamps only exist when NIGHT_FLASH_EN is defined.
module tl_light_decode
    import tl_pkg::*;
(
    input  phase_e     phase,
    input  logic       blink,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk
);

`ifndef NIGHT_FLASH_EN
    logic unused_blink_s;
    assign unused_blink_s = blink;
`endif

    // Lamp pattern per phase; anything unexpected shows all-red
    always_comb begin
        main_light = RED;
        side_light = RED;
        ped_walk   = 1'b0;
        case (phase)
            MAIN_G:   main_light = GRN;
            MAIN_Y:   main_light = YEL;
            SIDE_G:   side_light = GRN;
            SIDE_Y:   side_light = YEL;
            PED_WALK: ped_walk   = 1'b1;
            FLASH: begin
`ifdef NIGHT_FLASH_EN
                main_light = blink ? YEL : OFF;
                side_light = blink ? RED : OFF;
`else
                main_light = RED;
                side_light = RED;
`endif
            end
            default: begin
                main_light = RED;
                side_light = RED;
                ped_walk   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tl_phase_fsm.sv
// Traffic-light phase sequencer driving a seconds timer via tl_phase_fsm_if.
// Optional night flashing mode is built when NIGHT_FLASH_EN is defined.
module tl_phase_fsm
    import tl_pkg::*;
#(
    parameter int T_MAIN_G = DEF_T_MAIN_G,
    parameter int T_SIDE_G = DEF_T_SIDE_G,
    parameter int T_YELLOW = DEF_T_YELLOW,
    parameter int T_ALLRED = DEF_T_ALLRED,
    parameter int T_PED    = DEF_T_PED
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 ped_req,
    input  logic                 night,
    tl_phase_fsm_if.master       tmr,
    output logic [2:0]           main_light,
    output logic [2:0]           side_light,
    output logic                 ped_walk,
    output logic                 ped_pending
);

    phase_e      phase_r, phase_nxt_s;
    sub_e        sub_r, sub_nxt_s;
    logic        blink_r, blink_nxt_s;
    logic        ped_pending_r, ped_set_s, ped_nxt_s;
    logic        timer_enable_r;
    logic        timer_reset_r, timer_reset_s;
    logic [15:0] timer_seconds_r, timer_seconds_s;
    logic [2:0]  main_light_r, side_light_r, main_light_s, side_light_s;
    logic        ped_walk_r, ped_walk_s;

`ifndef NIGHT_FLASH_EN
    logic unused_night_s;
    assign unused_night_s = night;
`endif

    function automatic logic [15:0] phase_seconds(input phase_e p);
        case (p)
            MAIN_G:    return 16'(T_MAIN_G);
            MAIN_Y:    return 16'(T_YELLOW);
            ALL_RED_A: return 16'(T_ALLRED);
            SIDE_G:    return 16'(T_SIDE_G);
            SIDE_Y:    return 16'(T_YELLOW);
            ALL_RED_B: return 16'(T_ALLRED);
            PED_WALK:  return 16'(T_PED);
            FLASH:     return 16'd1;
            default:   return 16'(T_ALLRED);
        endcase
    endfunction

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            phase_r         <= ALL_RED_B;
            sub_r           <= LOAD;
            blink_r         <= 1'b0;
            ped_pending_r   <= 1'b0;
            timer_enable_r  <= 1'b1;
            timer_reset_r   <= 1'b1;
            timer_seconds_r <= 16'(T_ALLRED);
            main_light_r    <= RED;
            side_light_r    <= RED;
            ped_walk_r      <= 1'b0;
        end else begin
            phase_r         <= phase_nxt_s;
            sub_r           <= sub_nxt_s;
            blink_r         <= blink_nxt_s;
            ped_pending_r   <= ped_nxt_s;
            timer_enable_r  <= 1'b1;
            timer_reset_r   <= timer_reset_s;
            timer_seconds_r <= timer_seconds_s;
            main_light_r    <= main_light_s;
            side_light_r    <= side_light_s;
            ped_walk_r      <= ped_walk_s;
        end
    end

    // Next phase/sub-state; the successor decision already sees this cycle's request
    always_comb begin
        phase_nxt_s = phase_r;
        sub_nxt_s   = sub_r;
        blink_nxt_s = blink_r;
        ped_set_s   = ped_pending_r | (ped_req & (phase_r != PED_WALK));
        case (sub_r)
            LOAD:   sub_nxt_s = SETTLE;
            SETTLE: sub_nxt_s = RUN;
            RUN: begin
                if (tmr.timer_finished) begin
                    sub_nxt_s   = LOAD;
                    phase_nxt_s = next_phase(phase_r, ped_set_s);
`ifdef NIGHT_FLASH_EN
                    if (night) begin
                        phase_nxt_s = FLASH;
                        blink_nxt_s = (phase_r == FLASH) ? ~blink_r : 1'b1;
                    end else begin
                        blink_nxt_s = 1'b0;
                    end
`endif
                end else begin
                    sub_nxt_s = RUN;
                end
            end
            default: begin
                sub_nxt_s   = LOAD;
                phase_nxt_s = ALL_RED_B;
            end
        endcase
        // Entering the walk serves the request; clear beats a simultaneous set
        ped_nxt_s = ((sub_nxt_s == LOAD) && (phase_nxt_s == PED_WALK)) ? 1'b0 : ped_set_s;
    end

    // Timer controls follow the state being entered
    always_comb begin
        timer_reset_s   = (sub_nxt_s == LOAD);
        timer_seconds_s = phase_seconds(phase_nxt_s);
    end

    tl_light_decode u_light_decode (
        .phase      (phase_nxt_s),
        .blink      (blink_nxt_s),
        .main_light (main_light_s),
        .side_light (side_light_s),
        .ped_walk   (ped_walk_s)
    );

    assign tmr.timer_enable  = timer_enable_r;
    assign tmr.timer_reset   = timer_reset_r;
    assign tmr.timer_seconds = timer_seconds_r;
    assign main_light        = main_light_r;
    assign side_light        = side_light_r;
    assign ped_walk          = ped_walk_r;
    assign ped_pending       = ped_pending_r;

endmodule

// File: tb/tb_tl_phase_fsm.sv
// Bench for tl_phase_fsm: scaled seconds timer model plus a phase-level reference model.
module tb_tl_phase_fsm;
    localparam int K   = 3;   // clock cycles per "second" in the timer model
    localparam int TMG = 3;
    localparam int TSG = 2;
    localparam int TY  = 1;
    localparam int TAR = 2;
    localparam int TP  = 3;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic       force_fin = 1'b0;
    logic [2:0] main_light, side_light;
    logic       ped_walk, ped_pending;

    tl_phase_fsm_if tif();

    tl_phase_fsm #(.T_MAIN_G(TMG), .T_SIDE_G(TSG), .T_YELLOW(TY), .T_ALLRED(TAR), .T_PED(TP)) dut (
        .CLK(CLK), .reset(reset), .ped_req(ped_req), .night(night), .tmr(tif),
        .main_light(main_light), .side_light(side_light), .ped_walk(ped_walk), .ped_pending(ped_pending)
    );

    always #5 CLK = ~CLK;

    // Seconds timer model: finished echoes its own reset, then rises after N*K cycles
    int   tcnt, ttgt;
    logic fin_r;
    always @(posedge CLK) begin
        if (reset) begin
            tcnt <= 0; ttgt <= 0; fin_r <= 1'b0;
        end else if (tif.timer_enable && tif.timer_reset) begin
            tcnt <= 0; ttgt <= int'(tif.timer_seconds) * K; fin_r <= 1'b1;
        end else if (tif.timer_enable) begin
            tcnt <= tcnt + 1; fin_r <= (tcnt + 1 >= ttgt);
        end else begin
            tcnt <= tcnt; fin_r <= fin_r;
        end
    end
    assign tif.timer_finished = fin_r | force_fin;

    // Reference model: phase index 0..7 = MAIN_G MAIN_Y ALL_RED_A SIDE_G SIDE_Y ALL_RED_B PED_WALK FLASH
    int m_ph = 5, m_cyc = 0;
    bit m_pend = 1'b0, m_blink = 1'b0;
    int checks = 0, errors = 0;

    function automatic int sec_of(input int p);
        case (p)
            0: return TMG;
            1: return TY;
            2: return TAR;
            3: return TSG;
            4: return TY;
            5: return TAR;
            6: return TP;
            default: return 1;
        endcase
    endfunction

    function automatic logic [25:0] exp_vec();
        logic [2:0] em, es;
        em = 3'b100; es = 3'b100;
        case (m_ph)
            0: em = 3'b001;
            1: em = 3'b010;
            3: es = 3'b001;
            4: es = 3'b010;
            7: begin em = m_blink ? 3'b010 : 3'b000; es = m_blink ? 3'b100 : 3'b000; end
            default: ;
        endcase
        return {em, es, (m_ph == 6), m_pend, 1'b1, (m_cyc == 0), 16'(sec_of(m_ph))};
    endfunction

    function automatic logic [25:0] obs();
        return {main_light, side_light, ped_walk, ped_pending, tif.timer_enable, tif.timer_reset, tif.timer_seconds};
    endfunction

    task automatic step(input bit req, input bit nt, input bit rst, input bit frc);
        int nph;
        @(negedge CLK);
        ped_req = req; night = nt; reset = rst; force_fin = frc;
        @(posedge CLK);
        #1;
        if (rst) begin
            m_ph = 5; m_cyc = 0; m_pend = 1'b0; m_blink = 1'b0;
        end else begin
            if (req && m_ph != 6) m_pend = 1'b1;
            if (m_cyc + 1 == sec_of(m_ph) * K + 2) begin
                if (m_ph == 5)      nph = m_pend ? 6 : 0;
                else if (m_ph == 6) nph = 0;
                else if (m_ph == 7) nph = 5;
                else                nph = m_ph + 1;
`ifdef NIGHT_FLASH_EN
                if (nt) begin m_blink = (m_ph == 7) ? ~m_blink : 1'b1; nph = 7; end
                else m_blink = 1'b0;
`endif
                if (nph == 6) m_pend = 1'b0;
                m_ph = nph; m_cyc = 0;
            end else begin
                m_cyc++;
            end
        end
    endtask

    task automatic advance_to(input int p, input int c, input bit nt, input string tag);
        int n = 0;
        while (!(m_ph == p && m_cyc == c) && n < 300) begin
            step(1'b0, nt, 1'b0, 1'b0);
            n++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL %s ph%0d cyc%0d: got %h want %h", tag, m_ph, m_cyc, obs(), exp_vec());
            end
        end
        checks++;
        if (!(m_ph == p && m_cyc == c)) begin
            errors++;
            $display("FAIL %s_timeout: reached ph%0d cyc%0d, wanted ph%0d cyc%0d", tag, m_ph, m_cyc, p, c);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs() !== {3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2}) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs(), {3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2});
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (main_light !== 3'b100 || tif.timer_reset !== 1'b0 || tif.timer_seconds !== 16'd2) begin
                errors++; $display("FAIL startup_allred: cycle %0d main %b reset %b secs %0d want 100/0/2", i, main_light, tif.timer_reset, tif.timer_seconds);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (main_light !== 3'b001 || tif.timer_reset !== 1'b1 || tif.timer_seconds !== 16'(TMG)) begin
            errors++; $display("FAIL startup_main_g: main %b reset %b secs %0d want 001/1/%0d", main_light, tif.timer_reset, tif.timer_seconds, TMG);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (main_light !== 3'b001 || tif.timer_reset !== 1'b0) begin
            errors++; $display("FAIL reset_pulse_width: main %b reset %b want 001/0", main_light, tif.timer_reset);
        end
    endtask

    task automatic test_full_cycle();
        logic [6:0] seen[$];
        logic [6:0] want[7] = '{7'b001_100_0, 7'b010_100_0, 7'b100_100_0, 7'b100_001_0,
                                7'b100_010_0, 7'b100_100_0, 7'b001_100_0};
        advance_to(0, 0, 1'b0, "to_main_g");
        seen.push_back({main_light, side_light, ped_walk});
        for (int i = 0; i < 45; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (tif.timer_reset === 1'b1) seen.push_back({main_light, side_light, ped_walk});
            checks++;
            if ($countones(main_light) > 1 || $countones(side_light) > 1 ||
                (main_light[1:0] != 2'b00 && side_light[1:0] != 2'b00)) begin
                errors++; $display("FAIL lamp_safety: main %b side %b", main_light, side_light);
            end
        end
        checks++;
        if (seen.size() != 7) begin
            errors++; $display("FAIL phase_count: got %0d entries want 7", seen.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    errors++; $display("FAIL phase_order[%0d]: got %b want %b", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_ped_walk();
        int walk_cycles = 0;
        advance_to(3, 2, 1'b0, "ped_to_side_g");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ped_pending !== 1'b1) begin errors++; $display("FAIL ped_set: got %b want 1", ped_pending); end
        advance_to(6, 0, 1'b0, "ped_to_walk");
        checks++;
        if (ped_pending !== 1'b0 || ped_walk !== 1'b1) begin
            errors++; $display("FAIL ped_walk_load: pending %b walk %b want 0/1", ped_pending, ped_walk);
        end
        for (int i = 0; i < 100 && m_ph == 6; i++) begin
            if (ped_walk === 1'b1) walk_cycles++;
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (walk_cycles != TP * K + 2 || main_light !== 3'b001) begin
            errors++; $display("FAIL ped_walk_len: walk %0d cycles main %b want %0d/001", walk_cycles, main_light, TP * K + 2);
        end
    endtask

    task automatic test_ped_during_walk();
        advance_to(3, 2, 1'b0, "pdw_to_side_g");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        advance_to(6, 3, 1'b0, "pdw_to_walk");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ped_pending !== 1'b0) begin errors++; $display("FAIL ped_dropped: got %b want 0", ped_pending); end
        advance_to(5, 0, 1'b0, "pdw_to_allred_b");
        advance_to(0, 0, 1'b0, "pdw_to_main_g");
        checks++;
        if (ped_walk !== 1'b0 || main_light !== 3'b001) begin
            errors++; $display("FAIL no_second_walk: walk %b main %b want 0/001", ped_walk, main_light);
        end
    endtask

    task automatic test_same_cycle_serve();
        advance_to(5, TAR * K + 1, 1'b0, "late_to_allred_b");
        checks++;
        if (ped_pending !== 1'b0 || tif.timer_finished !== 1'b1) begin
            errors++; $display("FAIL late_setup: pending %b finished %b want 0/1", ped_pending, tif.timer_finished);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ped_walk !== 1'b1 || ped_pending !== 1'b0 || tif.timer_reset !== 1'b1) begin
            errors++; $display("FAIL late_served: walk %b pending %b reset %b want 1/0/1", ped_walk, ped_pending, tif.timer_reset);
        end
        advance_to(0, 0, 1'b0, "late_to_main_g");
    endtask

    task automatic test_settle_force_and_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0, (m_cyc <= 1));
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL settle_force ph%0d cyc%0d: got %h want %h", m_ph, m_cyc, obs(), exp_vec());
            end
        end
        advance_to(0, 4, 1'b0, "mid_main_g");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ped_pending !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", ped_pending); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs() !== {3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2}) begin
            errors++; $display("FAIL mid_reset: got %h want %h", obs(), {3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2});
        end
        advance_to(0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        bit req, nt;
        for (int i = 0; i < 800; i++) begin
            req = ($urandom_range(15) == 0);
            nt  = ($urandom_range(7) == 0);
            step(req, nt, 1'b0, 1'b0);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++; $display("FAIL random ph%0d cyc%0d: got %h want %h", m_ph, m_cyc, obs(), exp_vec());
            end
        end
        advance_to(0, 0, 1'b0, "random_settle");
    endtask

`ifdef NIGHT_FLASH_EN
    task automatic test_night();
        logic [2:0] seen[$];
        advance_to(3, 2, 1'b1, "night_side_g");
        advance_to(7, 0, 1'b1, "night_flash");
        for (int i = 0; i < 3 * (K + 2); i++) begin
            if (tif.timer_reset === 1'b1) seen.push_back(main_light);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (seen.size() < 3 || seen[0] !== 3'b010 || seen[1] !== 3'b000 || seen[2] !== 3'b010) begin
            errors++; $display("FAIL night_blink: saw %0d entries first %b want 010,000,010", seen.size(), (seen.size() > 0) ? seen[0] : 3'bxxx);
        end
        advance_to(5, 0, 1'b0, "night_exit");
        advance_to(0, 0, 1'b0, "night_main_g");
        checks++;
        if (main_light !== 3'b001) begin errors++; $display("FAIL night_resume: main %b want 001", main_light); end
    endtask
`else
    task automatic test_night();
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (main_light === 3'b000 || side_light === 3'b000 || obs() !== exp_vec()) begin
                errors++; $display("FAIL night_ignored: got %h want %h", obs(), exp_vec());
            end
        end
        advance_to(0, 0, 1'b0, "night_main_g");
    endtask
`endif

    initial begin
        test_reset();
        test_full_cycle();
        test_ped_walk();
        test_ped_during_walk();
        test_same_cycle_serve();
        test_settle_force_and_reset();
        test_night();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
